fft_control_gen: RTL and testbench
==================================

FFT_CONTROL_GEN -- requirements
Module: fft_control_gen

Interface
REQ-001 SHALL have parameter LOG2_N, default 11, meaning log2 of FFT size; legal range 4..14.
REQ-002 SHALL have parameter PIPE_DLY, default 5, meaning read-to-write-data latency of the butterfly/multiplier datapath in cycles; legal range 1..15.
REQ-003 SHALL derive local constant AW = LOG2_N-2, the per-bank address width.
REQ-004 SHALL derive local constant DEPTH = 2^AW, the words per bank.
REQ-005 SHALL derive local constant NST = ceil(LOG2_N/2), the stage count.
REQ-006 SHALL have port iCLK  in  1  single clock; all logic rising-edge.
REQ-007 SHALL have port iRESET  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have port iSTART  in  1  start pulse, honoured only in IDLE.
REQ-009 SHALL have port iABORT  in  1  synchronous abort of a running transform.
REQ-010 SHALL have port iINVERSE  in  1  inverse-FFT request, sampled with accepted iSTART.
REQ-011 SHALL have ports oADDR_RD_0..oADDR_RD_3  out  AW each  bank read addresses.
REQ-012 SHALL have port oADDR_WR  out  AW  write address.
REQ-013 SHALL have port oADDR_COEF  out  AW  twiddle ROM address.
REQ-014 SHALL have ports oBANK_RD_ROT, oBANK_WR_ROT  out  2 each  bank rotation selects.
REQ-015 SHALL have ports oWE_A, oWE_B  out  1 each  write enables of ping-pong RAM sets A/B.
REQ-016 SHALL have port oSOURCE_DATA  out  1  1 = datapath reads input buffer.
REQ-017 SHALL have port oBUT_TYPE  out  1  0 = radix-4, 1 = radix-2 butterfly.
REQ-018 SHALL have port oCONJ  out  1  conjugate twiddles (inverse mode).
REQ-019 SHALL have port oSTAGE  out  4  current stage index.
REQ-020 SHALL have ports oBUSY, oRDY  out  1 each  busy/ready status.
REQ-021 SHALL have port oDONE  out  1  one-cycle completion pulse.

Function
REQ-022 SHALL implement the FSM IDLE->READ->DRAIN->(READ of next stage | DONE)->IDLE; DONE lasts exactly 1 cycle.
REQ-023 SHALL, on iSTART in IDLE, enter READ on the next edge with stage s=0, time counter t=0, and oCONJ=iINVERSE; iSTART outside IDLE SHALL be ignored.
REQ-024 SHALL run READ for t=0..DEPTH-1 and then DRAIN for PIPE_DLY cycles; each stage SHALL last DEPTH+PIPE_DLY cycles.
REQ-025 SHALL use block length L_s = max(DEPTH>>(2s), 1) and block index b = t/L_s.
REQ-026 SHALL, in READ, register all four oADDR_RD_k = t one cycle after t, and register oBANK_RD_ROT = b mod 4 one cycle after t.
REQ-027 SHALL register oADDR_COEF = ((t mod L_s) * 4^s) mod DEPTH in the same cycle as the read address.
REQ-028 SHALL hold oADDR_COEF at 0 outside READ.
REQ-029 SHALL, for the write window t' = t-PIPE_DLY in 0..DEPTH-1, drive oADDR_WR = t' and oBANK_WR_ROT = (t'/L_s) mod 4.
REQ-030 SHALL assert oWE_B on even stages and oWE_A on odd stages, only within the write window.
REQ-031 SHALL keep both write enables low at all other times and never assert them together.
REQ-032 SHALL assert oSOURCE_DATA during stage-0 READ only.
REQ-033 SHALL assert oBUT_TYPE=1 throughout stage NST-1 when LOG2_N is odd, and 0 otherwise.
REQ-034 SHALL keep oSTAGE = s during READ and DRAIN.
REQ-035 SHALL drive oBUSY=1 in READ and DRAIN, and oRDY = !oBUSY.
REQ-036 SHALL assert oDONE in the DONE state only.
REQ-037 SHALL, on iABORT in READ or DRAIN, go to IDLE on the next edge: write enables low that cycle, no oDONE, counters cleared.
REQ-038 SHALL, when iABORT and iSTART coincide in IDLE, give iABORT priority (no start).
REQ-039 SHALL make all counters wrap-free: t SHALL never exceed DEPTH+PIPE_DLY-1, and address arithmetic SHALL truncate to AW bits.

Reset
REQ-040 SHALL, while iRESET=1, force state IDLE and all counters 0, and drive all outputs 0 except oRDY=1.
REQ-041 SHALL make iRESET asserted mid-transform take effect immediately (asynchronously).
REQ-042 SHALL, after iRESET deassertion, accept iSTART on the first rising edge.

Verification
REQ-043 SHALL cover: defaults (LOG2_N=11, PIPE_DLY=5), iSTART pulse -> oDONE exactly 6*517+1 = 3103 cycles after the start edge; oBUT_TYPE=1 only in stage 5; 6 stages seen on oSTAGE.
REQ-044 SHALL cover: LOG2_N=8, PIPE_DLY=3 -> DEPTH=64, 4 stages, oDONE at cycle 4*67+1 = 269, oBUT_TYPE never 1.
REQ-045 SHALL cover: LOG2_N=11, stage 1 -> oBANK_RD_ROT increments every 128 reads; oADDR_COEF sequence 0,4,8,...,508 repeats 4 times.
REQ-046 SHALL cover: write window check -> oWE_B high for exactly DEPTH cycles in stage 0, oWE_A high for exactly DEPTH cycles in stage 1, and oADDR_WR runs 0..DEPTH-1 each stage.
REQ-047 SHALL cover: iABORT at stage 2, t=100 -> oBUSY=0 and write enables 0 the next cycle, no oDONE, and a new iSTART completes normally.
REQ-048 SHALL cover: iRESET pulse mid-stage 3, and iSTART while busy -> outputs return to reset values; the busy start is ignored with completion time unchanged.

Source files
------------

// File: rtl/fft_control_gen_if.sv
// Control-plane bundle between the FFT sequencer and its datapath.
// The sequencer uses the slave view; the datapath or a testbench uses the master view.
interface fft_control_gen_if #(
  parameter int LOG2_N = 11
);
  localparam int AW = LOG2_N - 2;

  logic          iSTART;
  logic          iABORT;
  logic          iINVERSE;
  logic [AW-1:0] oADDR_RD_0;
  logic [AW-1:0] oADDR_RD_1;
  logic [AW-1:0] oADDR_RD_2;
  logic [AW-1:0] oADDR_RD_3;
  logic [AW-1:0] oADDR_WR;
  logic [AW-1:0] oADDR_COEF;
  logic [1:0]    oBANK_RD_ROT;
  logic [1:0]    oBANK_WR_ROT;
  logic          oWE_A;
  logic          oWE_B;
  logic          oSOURCE_DATA;
  logic          oBUT_TYPE;
  logic          oCONJ;
  logic [3:0]    oSTAGE;
  logic          oBUSY;
  logic          oRDY;
  logic          oDONE;

  modport master (
    output iSTART, iABORT, iINVERSE,
    input  oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3, oADDR_WR, oADDR_COEF,
    input  oBANK_RD_ROT, oBANK_WR_ROT, oWE_A, oWE_B, oSOURCE_DATA, oBUT_TYPE,
    input  oCONJ, oSTAGE, oBUSY, oRDY, oDONE
  );

  modport slave (
    input  iSTART, iABORT, iINVERSE,
    output oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3, oADDR_WR, oADDR_COEF,
    output oBANK_RD_ROT, oBANK_WR_ROT, oWE_A, oWE_B, oSOURCE_DATA, oBUT_TYPE,
    output oCONJ, oSTAGE, oBUSY, oRDY, oDONE
  );
endinterface

// File: rtl/fft_control_gen.sv
// Stage sequencer for a radix-4 (with optional final radix-2) in-place FFT:
// generates bank read/write addresses, twiddle addresses and ping-pong write enables.
module fft_control_gen #(
  parameter int LOG2_N   = 11,
  parameter int PIPE_DLY = 5
) (
  input  logic             iCLK,
  input  logic             iRESET,
  fft_control_gen_if.slave bus
);
  localparam int AW    = LOG2_N - 2;
  localparam int DEPTH = 1 << AW;
  localparam int NST   = (LOG2_N + 1) / 2;
  localparam int TW    = AW + 1;

  localparam logic [TW-1:0] T_READ_LAST  = TW'(DEPTH - 1);
  localparam logic [TW-1:0] T_STAGE_LAST = TW'(DEPTH + PIPE_DLY - 1);
  localparam logic [TW-1:0] T_WR_FIRST   = TW'(PIPE_DLY);
  localparam logic [3:0]    S_LAST       = 4'(NST - 1);
  localparam logic          ODD_LOG      = 1'(LOG2_N % 2);
  localparam logic [AW-1:0] ALL_ONES     = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [TW-1:0] t_r;
  logic [3:0]    s_r;
  logic          conj_r;

  logic [4:0]    two_s_s, blk_sh_s;
  logic [AW-1:0] rd_addr_s, wr_addr_s, mask_s;
  logic          run_s, in_write_s;

  logic [AW-1:0] rd_addr_nx, wr_addr_nx, coef_nx;
  logic [1:0]    rd_rot_nx, wr_rot_nx;
  logic          we_a_nx, we_b_nx, src_nx, but_nx, conj_nx, busy_nx, rdy_nx, done_nx;
  logic [3:0]    stage_nx;

  logic [AW-1:0] rd_addr_r, wr_addr_r, coef_r;
  logic [1:0]    rd_rot_r, wr_rot_r;
  logic          we_a_r, we_b_r, src_r, but_r, conj_out_r, busy_r, rdy_r, done_r;
  logic [3:0]    stage_r;

  // State register
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // Next-state logic; abort wins over start and over stage progress
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.iABORT)      state_s = ST_IDLE;
        else if (bus.iSTART) state_s = ST_READ;
        else                 state_s = ST_IDLE;
      end
      ST_READ: begin
        if (bus.iABORT)              state_s = ST_IDLE;
        else if (t_r == T_READ_LAST) state_s = ST_DRAIN;
        else                         state_s = ST_READ;
      end
      ST_DRAIN: begin
        if (bus.iABORT)               state_s = ST_IDLE;
        else if (t_r == T_STAGE_LAST) state_s = (s_r == S_LAST) ? ST_DONE : ST_READ;
        else                          state_s = ST_DRAIN;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Time/stage counters follow the next state, so every exit from a stage clears them
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      t_r    <= {TW{1'b0}};
      s_r    <= 4'd0;
      conj_r <= 1'b0;
    end else if (state_s == ST_READ || state_s == ST_DRAIN) begin
      if (state_r == ST_IDLE) begin
        t_r    <= {TW{1'b0}};
        s_r    <= 4'd0;
        conj_r <= bus.iINVERSE;
      end else if (state_r == ST_DRAIN && state_s == ST_READ) begin
        t_r <= {TW{1'b0}};
        s_r <= s_r + 4'd1;
      end else begin
        t_r <= t_r + TW'(1);
      end
    end else begin
      t_r <= {TW{1'b0}};
      s_r <= 4'd0;
    end
  end

  // Block length is DEPTH/4^s (floor 1), so block index and offset are shift/mask of t
  assign two_s_s    = {s_r, 1'b0};
  assign blk_sh_s   = (two_s_s >= 5'(AW)) ? 5'd0 : 5'(AW) - two_s_s;
  assign mask_s     = ALL_ONES >> two_s_s;
  assign rd_addr_s  = t_r[AW-1:0];
  assign wr_addr_s  = AW'(t_r - T_WR_FIRST);
  assign run_s      = (state_r == ST_READ) || (state_r == ST_DRAIN);
  assign in_write_s = run_s && (t_r >= T_WR_FIRST);

  // Output decode from the current state; registered below
  always_comb begin
    rd_addr_nx = {AW{1'b0}};
    wr_addr_nx = {AW{1'b0}};
    coef_nx    = {AW{1'b0}};
    rd_rot_nx  = 2'd0;
    wr_rot_nx  = 2'd0;
    we_a_nx    = 1'b0;
    we_b_nx    = 1'b0;
    src_nx     = 1'b0;
    but_nx     = 1'b0;
    conj_nx    = 1'b0;
    stage_nx   = 4'd0;
    busy_nx    = 1'b0;
    rdy_nx     = 1'b1;
    done_nx    = 1'b0;
    case (state_r)
      ST_READ, ST_DRAIN: begin
        if (!bus.iABORT) begin
          busy_nx  = 1'b1;
          rdy_nx   = 1'b0;
          stage_nx = s_r;
          conj_nx  = conj_r;
          but_nx   = ODD_LOG && (s_r == S_LAST);
          if (state_r == ST_READ) begin
            rd_addr_nx = rd_addr_s;
            rd_rot_nx  = 2'(rd_addr_s >> blk_sh_s);
            coef_nx    = AW'((rd_addr_s & mask_s) << two_s_s);
            src_nx     = (s_r == 4'd0);
          end else begin
            src_nx = 1'b0;
          end
          if (in_write_s) begin
            wr_addr_nx = wr_addr_s;
            wr_rot_nx  = 2'(wr_addr_s >> blk_sh_s);
            we_b_nx    = ~s_r[0];
            we_a_nx    = s_r[0];
          end else begin
            we_a_nx = 1'b0;
          end
        end else begin
          rdy_nx = 1'b1;
        end
      end
      ST_DONE: done_nx = 1'b1;
      default: done_nx = 1'b0;
    endcase
  end

  // Output registers
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      rd_addr_r  <= {AW{1'b0}};
      wr_addr_r  <= {AW{1'b0}};
      coef_r     <= {AW{1'b0}};
      rd_rot_r   <= 2'd0;
      wr_rot_r   <= 2'd0;
      we_a_r     <= 1'b0;
      we_b_r     <= 1'b0;
      src_r      <= 1'b0;
      but_r      <= 1'b0;
      conj_out_r <= 1'b0;
      stage_r    <= 4'd0;
      busy_r     <= 1'b0;
      rdy_r      <= 1'b1;
      done_r     <= 1'b0;
    end else begin
      rd_addr_r  <= rd_addr_nx;
      wr_addr_r  <= wr_addr_nx;
      coef_r     <= coef_nx;
      rd_rot_r   <= rd_rot_nx;
      wr_rot_r   <= wr_rot_nx;
      we_a_r     <= we_a_nx;
      we_b_r     <= we_b_nx;
      src_r      <= src_nx;
      but_r      <= but_nx;
      conj_out_r <= conj_nx;
      stage_r    <= stage_nx;
      busy_r     <= busy_nx;
      rdy_r      <= rdy_nx;
      done_r     <= done_nx;
    end
  end

  assign bus.oADDR_RD_0   = rd_addr_r;
  assign bus.oADDR_RD_1   = rd_addr_r;
  assign bus.oADDR_RD_2   = rd_addr_r;
  assign bus.oADDR_RD_3   = rd_addr_r;
  assign bus.oADDR_WR     = wr_addr_r;
  assign bus.oADDR_COEF   = coef_r;
  assign bus.oBANK_RD_ROT = rd_rot_r;
  assign bus.oBANK_WR_ROT = wr_rot_r;
  assign bus.oWE_A        = we_a_r;
  assign bus.oWE_B        = we_b_r;
  assign bus.oSOURCE_DATA = src_r;
  assign bus.oBUT_TYPE    = but_r;
  assign bus.oCONJ        = conj_out_r;
  assign bus.oSTAGE       = stage_r;
  assign bus.oBUSY        = busy_r;
  assign bus.oRDY         = rdy_r;
  assign bus.oDONE        = done_r;
endmodule

// File: tb/tb_fft_control_gen.sv
// Scoreboard bench for fft_control_gen in two configurations (11/5 and 8/3):
// expected per-cycle output traces are queued at start and popped by per-DUT monitors.
module tb_fft_control_gen;
  typedef struct packed {
    logic [11:0] rd0, rd1, rd2, rd3, wr, coef;
    logic [1:0]  brot, wrot;
    logic        we_a, we_b, src, but, conj;
    logic [3:0]  stage;
    logic        busy, rdy, done;
  } ovec_t;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  ovec_t qa[$];
  ovec_t qb[$];

  fft_control_gen_if #(.LOG2_N(11)) ifa ();
  fft_control_gen_if #(.LOG2_N(8))  ifb ();

  fft_control_gen #(.LOG2_N(11), .PIPE_DLY(5)) dut_a (.iCLK(clk), .iRESET(rst_a), .bus(ifa));
  fft_control_gen #(.LOG2_N(8),  .PIPE_DLY(3)) dut_b (.iCLK(clk), .iRESET(rst_b), .bus(ifb));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic ovec_t idle_vec();
    ovec_t v;
    v = '0;
    v.rdy = 1'b1;
    return v;
  endfunction

  // Expected outputs for stage s, stage-time t, straight from the address rules
  function automatic ovec_t model_busy(input int log2n, input int p, input int s,
                                       input int t, input bit inv);
    ovec_t v;
    int depth, nst, pow4, len, tw;
    v     = '0;
    depth = 2 ** (log2n - 2);
    nst   = (log2n + 1) / 2;
    pow4  = 4 ** s;
    len   = depth / pow4;
    if (len < 1) len = 1;
    v.busy  = 1'b1;
    v.stage = 4'(s);
    v.conj  = inv;
    v.but   = ((log2n % 2) == 1) && (s == nst - 1);
    if (t < depth) begin
      v.rd0  = 12'(t);
      v.rd1  = 12'(t);
      v.rd2  = 12'(t);
      v.rd3  = 12'(t);
      v.brot = 2'((t / len) % 4);
      v.coef = 12'(((t % len) * pow4) % depth);
      v.src  = (s == 0);
    end
    tw = t - p;
    if (tw >= 0 && tw < depth) begin
      v.wr   = 12'(tw);
      v.wrot = 2'((tw / len) % 4);
      v.we_b = ((s % 2) == 0);
      v.we_a = ((s % 2) == 1);
    end
    return v;
  endfunction

  task automatic push(input int d, input ovec_t v);
    if (d == 0) qa.push_back(v);
    else        qb.push_back(v);
  endtask

  task automatic push_trace(input int d, input int log2n, input int p, input bit inv);
    int depth, nst;
    ovec_t dv;
    depth = 2 ** (log2n - 2);
    nst   = (log2n + 1) / 2;
    push(d, idle_vec());
    push(d, idle_vec());
    for (int s = 0; s < nst; s++)
      for (int t = 0; t < depth + p; t++)
        push(d, model_busy(log2n, p, s, t, inv));
    dv = idle_vec();
    dv.done = 1'b1;
    push(d, dv);
  endtask

  task automatic drive(input int d, input bit st, input bit ab, input bit inv);
    if (d == 0) begin
      ifa.iSTART = st; ifa.iABORT = ab; ifa.iINVERSE = inv;
    end else begin
      ifb.iSTART = st; ifb.iABORT = ab; ifb.iINVERSE = inv;
    end
  endtask

  function automatic bit get_done(input int d);
    return (d == 0) ? ifa.oDONE : ifb.oDONE;
  endfunction

  // kind: 0 plain, 1 abort at cycle 'at', 2 reset at 'at', 3 ignored start at 'at'
  task automatic run(input int d, input bit inv, input int kind, input int at);
    int log2n, p, nst, sl, n, n_done, budget, want;
    log2n  = (d == 0) ? 11 : 8;
    p      = (d == 0) ? 5 : 3;
    nst    = (log2n + 1) / 2;
    sl     = 2 ** (log2n - 2) + p;
    drive(d, 1'b1, 1'b0, inv);
    push_trace(d, log2n, p, inv);
    @(posedge clk); #1;
    drive(d, 1'b0, 1'b0, inv);
    n      = 0;
    n_done = -1;
    budget = nst * sl + 10;
    while (n < budget) begin
      @(posedge clk); #1;
      n++;
      drive(d, 1'b0, 1'b0, inv);
      if (n_done < 0 && get_done(d)) n_done = n;
      if (n == at && kind == 1) begin
        drive(d, 1'b0, 1'b1, inv);
        if (d == 0) while (qa.size() > 1) void'(qa.pop_back());
        else        while (qb.size() > 1) void'(qb.pop_back());
      end
      if (n == at && kind == 3) drive(d, 1'b1, 1'b0, ~inv);
      if (n == at && kind == 2) begin
        if (d == 0) begin rst_a = 1'b1; qa.delete(); end
        else        begin rst_b = 1'b1; qb.delete(); end
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        break;
      end
      if (kind == 1 && n >= at + 8) break;
      if (n_done >= 0 && n >= n_done + 3) break;
    end
    want = (kind == 0 || kind == 3) ? nst * sl + 1 : -1;
    checks++;
    if (n_done != want) begin
      errors++;
      $display("FAIL done_latency dut=%0d kind=%0d got=%0d want=%0d", d, kind, n_done, want);
    end
  endtask

  // Monitor for the 11/5 instance
  always @(negedge clk) begin : mon_a
    ovec_t g, e;
    g = '0;
    g.rd0 = 12'(ifa.oADDR_RD_0); g.rd1 = 12'(ifa.oADDR_RD_1);
    g.rd2 = 12'(ifa.oADDR_RD_2); g.rd3 = 12'(ifa.oADDR_RD_3);
    g.wr = 12'(ifa.oADDR_WR); g.coef = 12'(ifa.oADDR_COEF);
    g.brot = ifa.oBANK_RD_ROT; g.wrot = ifa.oBANK_WR_ROT;
    g.we_a = ifa.oWE_A; g.we_b = ifa.oWE_B; g.src = ifa.oSOURCE_DATA;
    g.but = ifa.oBUT_TYPE; g.conj = ifa.oCONJ; g.stage = ifa.oSTAGE;
    g.busy = ifa.oBUSY; g.rdy = ifa.oRDY; g.done = ifa.oDONE;
    if (qa.size() > 0) e = qa.pop_front();
    else               e = idle_vec();
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL mon_a cycle %0d got=%h want=%h", cyc, g, e);
    end
  end

  // Monitor for the 8/3 instance
  always @(negedge clk) begin : mon_b
    ovec_t g, e;
    g = '0;
    g.rd0 = 12'(ifb.oADDR_RD_0); g.rd1 = 12'(ifb.oADDR_RD_1);
    g.rd2 = 12'(ifb.oADDR_RD_2); g.rd3 = 12'(ifb.oADDR_RD_3);
    g.wr = 12'(ifb.oADDR_WR); g.coef = 12'(ifb.oADDR_COEF);
    g.brot = ifb.oBANK_RD_ROT; g.wrot = ifb.oBANK_WR_ROT;
    g.we_a = ifb.oWE_A; g.we_b = ifb.oWE_B; g.src = ifb.oSOURCE_DATA;
    g.but = ifb.oBUT_TYPE; g.conj = ifb.oCONJ; g.stage = ifb.oSTAGE;
    g.busy = ifb.oBUSY; g.rdy = ifb.oRDY; g.done = ifb.oDONE;
    if (qb.size() > 0) e = qb.pop_front();
    else               e = idle_vec();
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL mon_b cycle %0d got=%h want=%h", cyc, g, e);
    end
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;

    run(0, 1'b0, 0, -1);
    run(0, 1'b1, 3, int'($urandom_range(1, 3102)));
    run(0, 1'($urandom_range(0, 1)), 1, 2 * 517 + 100);
    run(0, 1'b0, 0, -1);
    run(0, 1'b1, 2, 3 * 517 + 200);
    run(0, 1'b1, 0, -1);

    run(1, 1'b0, 0, -1);
    run(1, 1'b1, 1, int'($urandom_range(1, 267)));
    run(1, 1'($urandom_range(0, 1)), 3, int'($urandom_range(1, 268)));
    run(1, 1'b0, 2, int'($urandom_range(1, 267)));
    run(1, 1'b1, 0, -1);

    repeat (5) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
